// File: rtl/lfo_multi.sv
// Multi-channel LFO: CHANNELS independent counters, each with its own limit, rate prescaler
// and waveform mode (triangle, saw up, saw down, one-shot), written through one register port.
module lfo_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int RATE_W   = 8,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW = (WIDTH > RATE_W) ? WIDTH : RATE_W
) (
  input  logic                      CK,
  input  logic                      RES,
  input  logic                      WR,
  input  logic [CW-1:0]             CH_SEL,
  input  logic [1:0]                REG_SEL,
  input  logic [DW-1:0]             DIN,
  output logic [CHANNELS*WIDTH-1:0] LFO_OUT,
  output logic [CHANNELS-1:0]       DIR,
  output logic [CHANNELS-1:0]       WRAP
);

  typedef enum logic [1:0] {
    M_TRI     = 2'd0,
    M_SAW_UP  = 2'd1,
    M_SAW_DN  = 2'd2,
    M_ONESHOT = 2'd3
  } mode_t;

  localparam logic [1:0] REG_LIM  = 2'd0;
  localparam logic [1:0] REG_RATE = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0]  r_val;
      logic [WIDTH-1:0]  r_lim;
      logic [RATE_W-1:0] r_rate;
      logic [RATE_W-1:0] r_pre;
      mode_t             r_mode;
      logic              r_dir;
      logic              r_wrap;
      logic              w_sel;
      logic [WIDTH-1:0]  w_nval;
      logic              w_ndir;
      logic              w_nwrap;

      assign w_sel = WR && (CH_SEL == CW'(gi));

      // Result of one step, using the current limit and direction.
      always_comb begin
        w_nval  = r_val;
        w_ndir  = r_dir;
        w_nwrap = 1'b0;
        case (r_mode)
          M_TRI: begin
            if (!r_dir) begin
              if (r_val >= r_lim) begin
                w_nval = r_val - WIDTH'(1);
                w_ndir = 1'b1;
              end else begin
                w_nval = r_val + WIDTH'(1);
              end
            end else if (r_val == '0) begin
              w_nval = r_val + WIDTH'(1);
              w_ndir = 1'b0;
            end else begin
              w_nval = r_val - WIDTH'(1);
            end
            w_nwrap = (w_nval == '0);
          end
          M_SAW_UP: begin
            w_ndir = 1'b0;
            if (r_val >= r_lim) begin
              w_nval  = '0;
              w_nwrap = 1'b1;
            end else begin
              w_nval = r_val + WIDTH'(1);
            end
          end
          M_SAW_DN: begin
            w_ndir = 1'b1;
            if (r_val > r_lim) begin
              w_nval = r_lim;
            end else if (r_val == '0) begin
              w_nval  = r_lim;
              w_nwrap = 1'b1;
            end else begin
              w_nval = r_val - WIDTH'(1);
            end
          end
          default: begin
            w_ndir = 1'b0;
            if (r_val < r_lim) begin
              w_nval  = r_val + WIDTH'(1);
              w_nwrap = (w_nval == r_lim);
            end
          end
        endcase
      end

      always_ff @(posedge CK) begin
        if (RES) begin
          r_val  <= '0;
          r_lim  <= '0;
          r_rate <= '0;
          r_pre  <= '0;
          r_mode <= M_TRI;
          r_dir  <= 1'b0;
          r_wrap <= 1'b0;
        end else begin
          if (w_sel && REG_SEL == REG_LIM)  r_lim  <= DIN[WIDTH-1:0];
          if (w_sel && REG_SEL == REG_RATE) r_rate <= DIN[RATE_W-1:0];
          // A mode write restarts the channel and overrides any step due this cycle.
          if (w_sel && REG_SEL == REG_MODE) begin
            r_mode <= mode_t'(DIN[1:0]);
            r_pre  <= '0;
            r_wrap <= 1'b0;
            r_dir  <= (DIN[1:0] == 2'd2) && (r_lim != '0);
            r_val  <= (DIN[1:0] == 2'd2) ? r_lim : '0;
          end else if (r_lim == '0) begin
            r_val  <= '0;
            r_dir  <= 1'b0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
          end else if (r_pre >= r_rate) begin
            r_pre  <= '0;
            r_val  <= w_nval;
            r_dir  <= w_ndir;
            r_wrap <= w_nwrap;
          end else begin
            r_pre  <= r_pre + RATE_W'(1);
            r_wrap <= 1'b0;
          end
        end
      end

      assign LFO_OUT[gi*WIDTH +: WIDTH] = r_val;
      assign DIR[gi]                    = r_dir;
      assign WRAP[gi]                   = r_wrap;
    end
  endgenerate

endmodule

// File: tb/tb_lfo_multi.sv
// Bench for lfo_multi: directed test-plan scenarios and random register traffic, every cycle
// compared against an integer model of the per-channel rules.
module tb_lfo_multi;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic           CK = 1'b0;
  logic           RES = 1'b1;
  logic           WR = 1'b0;
  logic [0:0]     CH_SEL = '0;
  logic [1:0]     REG_SEL = '0;
  logic [7:0]     DIN = '0;
  logic [NCH*W-1:0] LFO_OUT;
  logic [NCH-1:0] DIR;
  logic [NCH-1:0] WRAP;

  lfo_multi #(.CHANNELS(NCH), .WIDTH(W), .RATE_W(8)) dut (
    .CK(CK), .RES(RES), .WR(WR), .CH_SEL(CH_SEL), .REG_SEL(REG_SEL), .DIN(DIN),
    .LFO_OUT(LFO_OUT), .DIR(DIR), .WRAP(WRAP)
  );

  always #5 CK = ~CK;

  int n_total = 0;
  int n_bad   = 0;

  // Model state per channel.
  int m_v[NCH] = '{default: 0};
  int m_l[NCH] = '{default: 0};
  int m_r[NCH] = '{default: 0};
  int m_m[NCH] = '{default: 0};
  int m_d[NCH] = '{default: 0};
  int m_p[NCH] = '{default: 0};
  int m_w[NCH] = '{default: 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int n, input int lim);
    int v, nv, nd, nw;
    v = m_v[n]; nv = v; nd = m_d[n]; nw = 0;
    case (m_m[n])
      0: begin
        if (m_d[n] == 0) begin
          if (v >= lim) begin nv = v - 1; nd = 1; end
          else nv = v + 1;
        end else begin
          if (v == 0) begin nv = 1; nd = 0; end
          else nv = v - 1;
        end
        nw = (nv == 0);
      end
      1: begin
        nd = 0;
        if (v >= lim) begin nv = 0; nw = 1; end else nv = v + 1;
      end
      2: begin
        nd = 1;
        if (v > lim) nv = lim;
        else if (v == 0) begin nv = lim; nw = 1; end
        else nv = v - 1;
      end
      default: begin
        nd = 0;
        if (v < lim) begin nv = v + 1; nw = (nv == lim); end
      end
    endcase
    m_v[n] = nv & 255; m_d[n] = nd; m_w[n] = nw;
  endtask

  task automatic model_edge(input bit res, input bit wr, input int ch, input int rs, input int din);
    for (int n = 0; n < NCH; n++) begin
      int ol, orr;
      bit sel;
      if (res) begin
        m_v[n] = 0; m_l[n] = 0; m_r[n] = 0; m_m[n] = 0; m_d[n] = 0; m_p[n] = 0; m_w[n] = 0;
      end else begin
        ol = m_l[n]; orr = m_r[n];
        sel = wr && (ch == n);
        if (sel && rs == 0) m_l[n] = din & 255;
        if (sel && rs == 1) m_r[n] = din & 255;
        if (sel && rs == 2) begin
          m_m[n] = din & 3;
          m_p[n] = 0; m_w[n] = 0;
          m_d[n] = (m_m[n] == 2 && ol != 0) ? 1 : 0;
          m_v[n] = (m_m[n] == 2) ? ol : 0;
        end else if (ol == 0) begin
          m_v[n] = 0; m_d[n] = 0; m_p[n] = 0; m_w[n] = 0;
        end else if (m_p[n] >= orr) begin
          m_p[n] = 0;
          model_step(n, ol);
        end else begin
          m_p[n]++;
          m_w[n] = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance DUT and model together, compare all outputs.
  task automatic cyc(input bit res, input bit wr, input int ch, input int rs, input int din);
    logic [NCH*W-1:0] e_out;
    logic [NCH-1:0]   e_dir, e_wrap;
    RES = res; WR = wr; CH_SEL = ch[0:0]; REG_SEL = rs[1:0]; DIN = din[7:0];
    if (wr) $display("t=%0t wr ch=%0d reg=%0d din=%0d res=%0d", $time, ch, rs, din, res);
    @(posedge CK);
    model_edge(res, wr, ch, rs, din);
    #1;
    for (int n = 0; n < NCH; n++) begin
      e_out[n*W +: W] = m_v[n][W-1:0];
      e_dir[n]        = m_d[n][0];
      e_wrap[n]       = m_w[n][0];
    end
    check("lfo_out", 32'(LFO_OUT), 32'(e_out));
    check("dir", 32'(DIR), 32'(e_dir));
    check("wrap", 32'(WRAP), 32'(e_wrap));
    RES = 1'b0; WR = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int tri_exp[8];
    int saw_exp[10];
    int wraps;
    tri_exp = '{0, 1, 2, 3, 2, 1, 0, 1};
    saw_exp = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_out", 32'(LFO_OUT), 32'd0);
    check("reset_dir", 32'(DIR), 32'd0);
    check("reset_wrap", 32'(WRAP), 32'd0);

    // Triangle on channel 0, L=3, R=0.
    cyc(0, 1, 0, 0, 3);
    cyc(0, 1, 0, 2, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      check("tri_val", 32'(LFO_OUT[7:0]), 32'(tri_exp[i]));
      check("tri_dir", 32'(DIR[0]), (i >= 4 && i <= 6) ? 32'd1 : 32'd0);
      check("tri_wrap", 32'(WRAP[0]), (i == 6) ? 32'd1 : 32'd0);
    end

    // Saw up on channel 1, L=2, R=2; channel 0 keeps running under the model.
    cyc(0, 1, 1, 0, 2);
    cyc(0, 1, 1, 1, 2);
    cyc(0, 1, 1, 2, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) idle(1);
      check("saw_val", 32'(LFO_OUT[15:8]), 32'(saw_exp[i]));
      check("saw_wrap", 32'(WRAP[1]), (i == 9) ? 32'd1 : 32'd0);
    end

    // Saw down with a limit reduction while V sits at the old limit.
    cyc(0, 1, 0, 0, 4);
    cyc(0, 1, 0, 1, 3);
    cyc(0, 1, 0, 2, 2);
    check("sawdn_start", 32'(LFO_OUT[7:0]), 32'd4);
    cyc(0, 1, 0, 0, 2);
    idle(3);
    check("sawdn_clip", 32'(LFO_OUT[7:0]), 32'd2);
    cyc(0, 1, 0, 1, 0);
    idle(6);

    // One-shot, L=5, R=1, then raise L to 7.
    cyc(0, 1, 0, 0, 5);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 1, 0, 2, 3);
    wraps = 0;
    for (int i = 0; i < 14; i++) begin
      idle(1);
      wraps += int'(WRAP[0]);
    end
    check("oneshot_val", 32'(LFO_OUT[7:0]), 32'd5);
    check("oneshot_wraps", 32'(wraps), 32'd1);
    cyc(0, 1, 0, 0, 7);
    idle(6);
    check("oneshot_resume", 32'(LFO_OUT[7:0]), 32'd7);

    // Disable mid-count, then L=1 triangle.
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 2, 0);
    cyc(0, 1, 0, 0, 6);
    idle(4);
    cyc(0, 1, 0, 0, 0);
    idle(1);
    check("dis_val", 32'(LFO_OUT[7:0]), 32'd0);
    check("dis_dir", 32'(DIR[0]), 32'd0);
    idle(4);
    check("dis_hold", 32'(LFO_OUT[7:0]), 32'd0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(1);
      check("l1_val", 32'(LFO_OUT[7:0]), 32'(i % 2));
    end

    // Reset with a simultaneous write; then a mode write in a step cycle.
    cyc(0, 1, 1, 0, 3);
    idle(3);
    cyc(1, 1, 0, 0, 5);
    check("res_wr_out", 32'(LFO_OUT), 32'd0);
    check("res_wr_dir", 32'(DIR), 32'd0);
    idle(3);
    check("res_wr_discard", 32'(LFO_OUT), 32'd0);
    cyc(0, 1, 0, 0, 5);
    cyc(0, 1, 0, 2, 1);
    idle(3);
    check("pre_restart", 32'(LFO_OUT[7:0]), 32'd3);
    cyc(0, 1, 0, 2, 1);
    check("restart", 32'(LFO_OUT[7:0]), 32'd0);

    // Random register traffic.
    for (int i = 0; i < 1500; i++) begin
      int r, ch, rs, din;
      r  = $urandom_range(0, 99);
      ch = $urandom_range(0, NCH - 1);
      rs = $urandom_range(0, 3);
      case (rs)
        0:       din = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
        1:       din = $urandom_range(0, 3);
        default: din = $urandom_range(0, 255);
      endcase
      if (r == 0)      cyc(1, $urandom_range(0, 1), ch, rs, din);
      else if (r < 12) cyc(0, 1, ch, rs, din);
      else             cyc(0, 0, ch, rs, din);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
